// File: rtl/rcb_ram_ctrl.sv
// Single-port table RAM arbiter: strategy lookups take priority over host writes,
// with a bounded-starvation slot that guarantees a pending write eventually wins.
`timescale 1ns/1ps

module rcb_ram_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hpb_wr_req,
  input  logic [ADDR_WIDTH-1:0]   hpb_wr_addr,
  input  logic [DATA_WIDTH-1:0]   hpb_wr_data,
  input  logic [DATA_WIDTH/8-1:0] hpb_wr_byte_en,
  output logic                    rcb_wr_done,
  input  logic                    lk_req_valid,
  input  logic [ADDR_WIDTH-1:0]   lk_req_addr,
  output logic                    lk_req_ready,
  output logic                    lk_rsp_valid,
  output logic [DATA_WIDTH-1:0]   lk_rsp_data,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PEND  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    REARM = 3'd4
  } wr_state_t;

  wr_state_t              state_reg;
  logic                   wr_done_reg;
  logic [CNT_WIDTH-1:0]   starve_cnt_reg;

  logic                   ram_en_reg;
  logic                   ram_we_reg;
  logic [ADDR_WIDTH-1:0]  ram_addr_reg;
  logic [BE_WIDTH-1:0]    ram_be_reg;
  logic [DATA_WIDTH-1:0]  ram_wdata_reg;
  logic [RD_LATENCY-1:0]  rd_pipe_reg;

  logic in_pend;
  logic force_slot;
  logic wr_grant;
  logic lk_accept;
  logic rd_issue;

  // Arbitration: a lookup wins unless the write has waited out its starvation budget.
  assign in_pend      = (state_reg == PEND);
  assign force_slot   = (starve_cnt_reg == CNT_MAX);
  assign wr_grant     = in_pend && hpb_wr_req && (!lk_req_valid || force_slot);
  assign lk_req_ready = !(in_pend && force_slot);
  assign lk_accept    = lk_req_valid && lk_req_ready;
  assign rd_issue     = ram_en_reg && !ram_we_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      wr_done_reg <= 1'b0;
    end else begin
      wr_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hpb_wr_req) state_reg <= PEND;
        end
        PEND: begin
          if (!hpb_wr_req)   state_reg <= IDLE;
          else if (wr_grant) state_reg <= WRITE;
        end
        WRITE: begin
          state_reg   <= DONE;
          wr_done_reg <= 1'b1;
        end
        DONE: begin
          state_reg <= REARM;
        end
        REARM: begin
          // The host must drop its level request before another write is taken.
          if (!hpb_wr_req) state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state_reg == IDLE || wr_grant) begin
      starve_cnt_reg <= '0;
    end else if (in_pend && lk_accept && starve_cnt_reg != CNT_MAX) begin
      starve_cnt_reg <= starve_cnt_reg + CNT_WIDTH'(1);
    end
  end

  // Grant and accept are mutually exclusive, so one RAM operation per cycle at most.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_be_reg    <= '0;
      ram_wdata_reg <= '0;
    end else if (wr_grant) begin
      ram_en_reg    <= 1'b1;
      ram_we_reg    <= 1'b1;
      ram_addr_reg  <= hpb_wr_addr;
      ram_be_reg    <= hpb_wr_byte_en;
      ram_wdata_reg <= hpb_wr_data;
    end else if (lk_accept) begin
      ram_en_reg    <= 1'b1;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= lk_req_addr;
      ram_be_reg    <= '0;
    end else begin
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_be_reg    <= '0;
    end
  end

  // Valid bits track each issued read through the RAM's fixed latency.
  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) rd_pipe_reg[gi] <= 1'b0;
          else       rd_pipe_reg[gi] <= rd_issue;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (reset) rd_pipe_reg[gi] <= 1'b0;
          else       rd_pipe_reg[gi] <= rd_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign lk_rsp_valid = rd_pipe_reg[RD_LATENCY-1];
  assign lk_rsp_data  = lk_rsp_valid ? ram_rdata : '0;
  assign rcb_wr_done  = wr_done_reg;
  assign ram_en       = ram_en_reg;
  assign ram_we       = ram_we_reg;
  assign ram_addr     = ram_addr_reg;
  assign ram_be       = ram_be_reg;
  assign ram_wdata    = ram_wdata_reg;

endmodule

// File: tb/tb_rcb_ram_ctrl.sv
// Bench for rcb_ram_ctrl: directed scenarios plus random traffic, all checked cycle by
// cycle against a memory/queue reference model derived from the arbitration rules.
`timescale 1ns/1ps

module tb_rcb_ram_ctrl;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int BW  = DW / 8;
  localparam int RDL = 2;
  localparam int SL  = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          hpb_wr_req;
  logic [AW-1:0] hpb_wr_addr;
  logic [DW-1:0] hpb_wr_data;
  logic [BW-1:0] hpb_wr_byte_en;
  logic          rcb_wr_done;
  logic          lk_req_valid;
  logic [AW-1:0] lk_req_addr;
  logic          lk_req_ready;
  logic          lk_rsp_valid;
  logic [DW-1:0] lk_rsp_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // second instance with STARVE_LIMIT = 0
  logic          z_req, z_lkv, z_ready, z_done, z_rsp_valid, z_en, z_we;
  logic [DW-1:0] z_rsp_data, z_wdata;
  logic [AW-1:0] z_addr;
  logic [BW-1:0] z_be;
  logic [DW-1:0] z_rdata = '0;

  rcb_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .reset(reset),
    .hpb_wr_req(hpb_wr_req), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
    .hpb_wr_byte_en(hpb_wr_byte_en), .rcb_wr_done(rcb_wr_done),
    .lk_req_valid(lk_req_valid), .lk_req_addr(lk_req_addr), .lk_req_ready(lk_req_ready),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_data(lk_rsp_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  rcb_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL), .STARVE_LIMIT(0)) u_dut_z (
    .clk(clk), .reset(reset),
    .hpb_wr_req(z_req), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
    .hpb_wr_byte_en(hpb_wr_byte_en), .rcb_wr_done(z_done),
    .lk_req_valid(z_lkv), .lk_req_addr(lk_req_addr), .lk_req_ready(z_ready),
    .lk_rsp_valid(z_rsp_valid), .lk_rsp_data(z_rsp_data),
    .ram_en(z_en), .ram_we(z_we), .ram_addr(z_addr), .ram_be(z_be),
    .ram_wdata(z_wdata), .ram_rdata(z_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i < 512) ? DW'(i) : '1;
  endfunction

  // RAM behavioural model with RDL-cycle registered read
  logic          preload;
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] rd_pipe [RDL];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
    end else if (ram_en && ram_we) begin
      for (int b = 0; b < BW; b++)
        if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    if (ram_en && !ram_we) rd_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RDL-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // stimulus for the current cycle
  bit            s_rst, s_req, s_lkv;
  logic [AW-1:0] s_addr, s_la;
  logic [DW-1:0] s_data;
  logic [BW-1:0] s_be;

  // reference model
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t          rsp_q[$];
  logic [DW-1:0] mem_model [DEPTH];
  bit            m_idle = 1, m_pend = 0;
  int            m_scnt = 0, rearm_from = 0, done_at = -1;
  bit            e_en = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [BW-1:0] e_be = '0;
  logic [DW-1:0] e_wdata = '0;
  int            z_base = -100;

  // observations
  int n_we, n_done, n_rsp, n_rdy_low, n_acc, we_cyc, done_cyc, rdy_low_cyc;
  logic [DW-1:0] last_rsp;

  task automatic step();
    bit exp_ready, acc, grant, exp_v;
    logic [DW-1:0] exp_d;
    int zk;
    @(negedge clk);
    exp_ready = !(m_pend && m_scnt == SL);
    check_eq("lk_req_ready", lk_req_ready, exp_ready);
    check_eq("ram_en", ram_en, e_en);
    check_eq("ram_we", ram_we, e_we);
    check_eq("ram_addr", ram_addr, e_addr);
    check_eq("ram_wdata", ram_wdata, e_wdata);
    if (e_en) check_eq("ram_be", ram_be, e_be);
    check_eq("rcb_wr_done", rcb_wr_done, cyc == done_at);
    exp_v = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
    exp_d = exp_v ? rsp_q[0].data : '0;
    if (exp_v) void'(rsp_q.pop_front());
    check_eq("lk_rsp_valid", lk_rsp_valid, exp_v);
    check_eq("lk_rsp_data", lk_rsp_data, exp_d);
    zk = cyc - z_base;
    if (zk >= 0 && zk < 8) begin
      check_eq("z_ready", z_ready, zk != 2);
      check_eq("z_we", z_we, zk == 3);
      check_eq("z_done", z_done, zk == 4);
    end
    if (ram_we) begin n_we++; we_cyc = cyc; end
    if (rcb_wr_done) begin n_done++; done_cyc = cyc; end
    if (lk_rsp_valid) begin n_rsp++; last_rsp = lk_rsp_data; end
    if (!lk_req_ready) begin n_rdy_low++; rdy_low_cyc = cyc; end
    if (s_lkv && lk_req_ready) n_acc++;

    reset = s_rst; hpb_wr_req = s_req; hpb_wr_addr = s_addr; hpb_wr_data = s_data;
    hpb_wr_byte_en = s_be; lk_req_valid = s_lkv; lk_req_addr = s_la;
    z_lkv = (zk >= 0 && zk < 8);
    z_req = (zk >= 1 && zk <= 3);

    if (s_rst) begin
      rsp_q.delete();
      m_idle = 1; m_pend = 0; m_scnt = 0; done_at = -1;
      e_en = 0; e_we = 0; e_addr = '0; e_be = '0; e_wdata = '0;
    end else begin
      acc   = s_lkv && exp_ready;
      grant = m_pend && s_req && (!s_lkv || m_scnt == SL);
      e_en = 0; e_we = 0; e_be = '0;
      if (grant) begin
        for (int b = 0; b < BW; b++)
          if (s_be[b]) mem_model[s_addr][8*b +: 8] = s_data[8*b +: 8];
        e_en = 1; e_we = 1; e_addr = s_addr; e_be = s_be; e_wdata = s_data;
        done_at = cyc + 2; rearm_from = cyc + 3;
      end else if (acc) begin
        rsp_q.push_back('{due: cyc + 1 + RDL, data: mem_model[s_la]});
        e_en = 1; e_addr = s_la;
      end
      if (m_idle) begin
        if (s_req) begin m_idle = 0; m_pend = 1; m_scnt = 0; end
      end else if (m_pend) begin
        if (!s_req) begin m_pend = 0; m_idle = 1; end
        else if (grant) m_pend = 0;
        else if (acc && m_scnt < SL) m_scnt++;
      end else if (cyc >= rearm_from && !s_req) begin
        m_idle = 1;
      end
    end
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, a, cool, req_start;
    reset = 1; preload = 1; hpb_wr_req = 0; hpb_wr_addr = '0; hpb_wr_data = '0;
    hpb_wr_byte_en = '0; lk_req_valid = 0; lk_req_addr = '0; z_req = 0; z_lkv = 0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = init_word(i);
    s_rst = 1; s_req = 0; s_lkv = 0; s_addr = '0; s_la = '0; s_data = '0; s_be = '0;
    repeat (3) step();
    s_rst = 0; preload = 0;
    repeat (2) step();

    // back-to-back lookups 0..15
    n_rsp = 0; n_rdy_low = 0;
    for (int i = 0; i < 16; i++) begin s_lkv = 1; s_la = AW'(i); step(); end
    s_lkv = 0; repeat (6) step();
    check_eq("b2b_rsp_count", n_rsp, 16);
    check_eq("b2b_ready_low", n_rdy_low, 0);
    check_eq("b2b_last_data", last_rsp, 64'd15);

    // idle write, request held high past done
    n_we = 0; n_done = 0;
    s_req = 1; s_addr = 10'h005; s_data = 64'h1122334455667788; s_be = 8'hFF;
    r = cyc; repeat (9) step();
    check_eq("idle_we_cycle", we_cyc, r + 2);
    check_eq("idle_done_cycle", done_cyc, r + 3);
    check_eq("idle_we_count", n_we, 1);
    check_eq("idle_done_count", n_done, 1);
    s_req = 0; step();
    s_req = 1; s_addr = 10'h006; s_data = 64'hCAFE_F00D_1234_5678; r = cyc;
    repeat (5) step();
    check_eq("rearm_we_cycle", we_cyc, r + 2);
    s_req = 0; repeat (3) step();

    // starvation under continuous lookups
    n_rdy_low = 0; n_we = 0; n_acc = 0;
    s_req = 1; s_addr = 10'h040; s_data = 64'h0123_4567_89AB_CDEF; s_be = 8'hFF; r = cyc;
    for (int i = 0; i < 14; i++) begin s_lkv = 1; s_la = AW'(i + 32); step(); end
    check_eq("starve_ready_low_count", n_rdy_low, 1);
    check_eq("starve_ready_low_cycle", rdy_low_cyc, r + 1 + SL);
    check_eq("starve_we_cycle", we_cyc, r + 2 + SL);
    check_eq("starve_accepts", n_acc, 13);
    s_req = 0; s_lkv = 0; repeat (6) step();

    // byte enables and read-after-write
    n_rsp = 0;
    s_req = 1; s_addr = 10'h200; s_data = 64'hAAAA_AAAA_BBBB_BBBB; s_be = 8'h0F;
    step(); step();
    s_lkv = 1; s_la = 10'h200; step();
    s_lkv = 0; repeat (6) step();
    check_eq("raw_rsp_count", n_rsp, 1);
    check_eq("raw_rsp_data", last_rsp, 64'hFFFF_FFFF_BBBB_BBBB);
    s_req = 0; repeat (2) step();

    // request withdrawal while pending
    n_we = 0; n_done = 0;
    s_req = 1; s_addr = 10'h010; s_data = 64'h5555; s_be = 8'hFF;
    for (int i = 0; i < 3; i++) begin s_lkv = 1; s_la = AW'(i); step(); end
    s_req = 0; step();
    s_lkv = 0; repeat (6) step();
    check_eq("withdraw_we_count", n_we, 0);
    check_eq("withdraw_done_count", n_done, 0);
    s_req = 1; r = cyc; repeat (5) step();
    check_eq("post_withdraw_we_cycle", we_cyc, r + 2);
    s_req = 0; repeat (2) step();

    // reset with two lookups in flight and the FSM in WRITE
    n_rsp = 0; n_done = 0;
    s_req = 1; s_addr = 10'h020; s_data = 64'h7777_8888_9999_AAAA; s_lkv = 0; step();
    s_lkv = 1; s_la = 10'h001; step();
    s_lkv = 0; step();
    s_lkv = 1; s_la = 10'h002; s_rst = 1; s_req = 0; step();
    s_rst = 0; s_lkv = 0; repeat (7) step();
    check_eq("rst_rsp_count", n_rsp, 0);
    check_eq("rst_done_count", n_done, 0);

    // STARVE_LIMIT = 0 instance: write granted in first PEND cycle
    z_base = cyc; repeat (10) step();

    // random traffic
    cool = 0; req_start = 0;
    for (int i = 0; i < 2000; i++) begin
      s_lkv = ((i % 64) < 40) ? 1'b1 : ($urandom_range(3) != 0);
      s_la = AW'($urandom_range(31));
      if (!s_req) begin
        if (cool > 0) cool--;
        else if ($urandom_range(5) == 0) begin
          s_req = 1; s_addr = AW'($urandom_range(31)); s_data = {$urandom, $urandom};
          s_be = BW'($urandom_range(255)); req_start = cyc;
        end
      end else if (done_at > req_start && cyc > done_at) begin
        s_req = 0; cool = $urandom_range(2);
      end else if (m_pend && $urandom_range(31) == 0) begin
        s_req = 0; cool = $urandom_range(2);
      end
      step();
    end
    s_req = 0; s_lkv = 0; repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
